// File: rtl/i2c_pkg.sv
// Shared widths and FSM state encoding for the I2C host FIFO front end.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;
    localparam int unsigned I2C_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        FIN    = 3'd4
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous show-ahead FIFO; rdata is the head and is valid whenever empty is low.
module i2c_sync_fifo
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [I2C_DATA_W-1:0] wdata,
    output logic [I2C_DATA_W-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           level
);

    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [I2C_DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_level == FULL_LVL);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    // Push while full is dropped even if a pop happens in the same cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/i2c_host_fifo_ctrl.sv
// Host front end for the I2C master: command check/launch FSM plus TX and RX byte FIFOs.
module i2c_host_fifo_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [I2C_CNT_W-1:0]  cmd_cnt,
    input  logic                  tx_wr_en,
    input  logic [I2C_DATA_W-1:0] tx_wdata,
    output logic                  tx_full,
    output logic [AW:0]           tx_level,
    input  logic                  rx_rd_en,
    output logic [I2C_DATA_W-1:0] rx_rdata,
    output logic                  rx_empty,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_start,
    output logic [I2C_ADDR_W-1:0] m_addr,
    output logic                  m_rw,
    output logic [I2C_CNT_W-1:0]  m_data_cnt,
    output logic [I2C_DATA_W-1:0] m_tx_data,
    input  logic                  i_txff_rd,
    input  logic [I2C_DATA_W-1:0] m_rx_data,
    input  logic                  i_rxff_wr,
    input  logic                  i2c_done
);

    // Wide enough for both an occupancy (DEPTH <= 16) and a byte count.
    localparam int unsigned CMPW    = 5;
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    i2c_state_e            r_state;
    i2c_state_e            w_state_next;
    logic [I2C_ADDR_W-1:0] r_addr;
    logic                  r_rw;
    logic [I2C_CNT_W-1:0]  r_cnt;
    logic [I2C_CNT_W-1:0]  r_xfer_cnt;
    logic                  w_tx_empty;
    logic                  w_rx_full;
    logic [AW:0]           w_rx_level;
    logic [AW:0]           w_rx_free;
    logic                  w_strobe;
    logic                  w_reject;

    assign m_addr     = r_addr;
    assign m_rw       = r_rw;
    assign m_data_cnt = r_cnt;
    assign w_rx_free  = w_rx_full ? '0 : DEPTH_L - w_rx_level;
    // Only the strobe matching the latched direction counts toward the transfer.
    assign w_strobe   = r_rw ? i_rxff_wr : i_txff_rd;
    assign w_reject   = (r_cnt == '0)
                     || (!r_rw && (w_tx_empty || (CMPW'(tx_level) < CMPW'(r_cnt))))
                     || (r_rw && (CMPW'(w_rx_free) < CMPW'(r_cnt)));

    i2c_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr_en),
        .pop   (i_txff_rd),
        .wdata (tx_wdata),
        .rdata (m_tx_data),
        .full  (tx_full),
        .empty (w_tx_empty),
        .level (tx_level)
    );

    i2c_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_rxff_wr),
        .pop   (rx_rd_en),
        .wdata (m_rx_data),
        .rdata (rx_rdata),
        .full  (w_rx_full),
        .empty (rx_empty),
        .level (w_rx_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_cnt      <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && cmd_valid) begin
                r_addr <= cmd_addr;
                r_rw   <= cmd_rw;
                r_cnt  <= cmd_cnt;
            end
            if (r_state == LAUNCH) begin
                r_xfer_cnt <= '0;
            end else if (r_state == RUN && w_strobe) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        m_start      = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_state_next = CHECK;
            end
            CHECK: begin
                if (w_reject) begin
                    done         = 1'b1;
                    err          = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                m_start      = 1'b1;
                busy         = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (i2c_done) w_state_next = FIN;
            end
            FIN: begin
                done         = 1'b1;
                err          = (r_xfer_cnt != r_cnt);
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_host_fifo_ctrl.sv
// Self-checking bench for i2c_host_fifo_ctrl against a queue-based reference model.
module tb_i2c_host_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [3:0] cmd_cnt = '0;
    logic       tx_wr_en = 1'b0, rx_rd_en = 1'b0;
    logic [7:0] tx_wdata = '0, m_rx_data = '0;
    logic       i_txff_rd = 1'b0, i_rxff_wr = 1'b0, i2c_done = 1'b0;
    logic       cmd_ready, tx_full, rx_empty, busy, done, err, m_start, m_rw;
    logic [AW:0] tx_level;
    logic [7:0] rx_rdata, m_tx_data;
    logic [6:0] m_addr;
    logic [3:0] m_data_cnt;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] rd_pat[$];
    int n_pass = 0;
    int n_total = 0;

    i2c_host_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_cnt(cmd_cnt),
        .tx_wr_en(tx_wr_en), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_level(tx_level),
        .rx_rd_en(rx_rd_en), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
        .busy(busy), .done(done), .err(err), .m_start(m_start),
        .m_addr(m_addr), .m_rw(m_rw), .m_data_cnt(m_data_cnt), .m_tx_data(m_tx_data),
        .i_txff_rd(i_txff_rd), .m_rx_data(m_rx_data), .i_rxff_wr(i_rxff_wr),
        .i2c_done(i2c_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    // Apply the current inputs to the FIFO model, then advance one clock.
    task automatic step();
        bit tx_pop, tx_push, rx_pop, rx_push;
        if (rst) begin
            txq.delete();
            rxq.delete();
        end else begin
            tx_pop  = i_txff_rd && txq.size() > 0;
            tx_push = tx_wr_en && txq.size() < DEPTH;
            rx_pop  = rx_rd_en && rxq.size() > 0;
            rx_push = i_rxff_wr && rxq.size() < DEPTH;
            if (tx_pop)  void'(txq.pop_front());
            if (tx_push) txq.push_back(tx_wdata);
            if (rx_pop)  void'(rxq.pop_front());
            if (rx_push) rxq.push_back(m_rx_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [7:0] b);
        tx_wr_en = 1'b1;
        tx_wdata = b;
        step();
        tx_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Issue one command and play the master side with nstrobe pops/pushes.
    task automatic do_xfer(input logic [6:0] addr, input logic rw, input logic [3:0] cnt,
                           input int nstrobe, input string tag);
        bit rej, coinc, exp_err;
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready: got %b required 1", tag, cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_rw    = rw;
        cmd_cnt   = cnt;
        step();
        cmd_valid = 1'b0;
        rej = (cnt == 0) || (!rw && txq.size() < int'(cnt)) || (rw && (DEPTH - rxq.size()) < int'(cnt));
        n_total++;
        if ({m_addr, m_rw, m_data_cnt} !== {addr, rw, cnt})
            $display("FAIL %s latch: got %h/%b/%0d required %h/%b/%0d",
                     tag, m_addr, m_rw, m_data_cnt, addr, rw, cnt);
        else n_pass++;
        n_total++;
        if ({done, err, m_start} !== (rej ? 3'b110 : 3'b000))
            $display("FAIL %s check_cycle done/err/start: got %b%b%b required %0s",
                     tag, done, err, m_start, rej ? "110" : "000");
        else n_pass++;
        step();
        if (rej) begin
            n_total++;
            if ({cmd_ready, m_start, busy} !== 3'b100)
                $display("FAIL %s after_reject ready/start/busy: got %b%b%b required 100",
                         tag, cmd_ready, m_start, busy);
            else n_pass++;
            return;
        end
        n_total++;
        if ({m_start, busy, done} !== 3'b110)
            $display("FAIL %s launch start/busy/done: got %b%b%b required 110",
                     tag, m_start, busy, done);
        else n_pass++;
        step();
        coinc = ($urandom_range(0, 1) == 1) && (nstrobe > 0);
        for (int i = 0; i < nstrobe; i++) begin
            n_total++;
            if ({busy, m_start, done} !== 3'b100)
                $display("FAIL %s run busy/start/done: got %b%b%b required 100",
                         tag, busy, m_start, done);
            else n_pass++;
            if (!rw) begin
                if (txq.size() > 0) begin
                    n_total++;
                    if (m_tx_data !== txq[0])
                        $display("FAIL %s m_tx_data: got %h required %h", tag, m_tx_data, txq[0]);
                    else n_pass++;
                end
                i_txff_rd = 1'b1;
            end else begin
                if (rd_pat.size() > 0) m_rx_data = rd_pat.pop_front();
                else m_rx_data = 8'($urandom);
                i_rxff_wr = 1'b1;
            end
            if (coinc && i == nstrobe - 1) i2c_done = 1'b1;
            step();
            i_txff_rd = 1'b0;
            i_rxff_wr = 1'b0;
        end
        if (!coinc) begin
            i2c_done = 1'b1;
            step();
        end
        i2c_done = 1'b0;
        exp_err = (nstrobe != int'(cnt));
        n_total++;
        if ({done, err, busy} !== {1'b1, exp_err, 1'b0})
            $display("FAIL %s fin done/err/busy: got %b%b%b required 1%b0",
                     tag, done, err, busy, exp_err);
        else n_pass++;
        n_total++;
        if (tx_level !== (AW+1)'(txq.size()) || m_addr !== addr)
            $display("FAIL %s fin tx_level/m_addr: got %0d/%h required %0d/%h",
                     tag, tx_level, m_addr, txq.size(), addr);
        else n_pass++;
        step();
        n_total++;
        if ({done, cmd_ready} !== 2'b01)
            $display("FAIL %s back_idle done/ready: got %b%b required 01", tag, done, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({busy, done, err, m_start, m_addr, m_rw, m_data_cnt, tx_full, tx_level, rx_empty,
             cmd_ready} !== {4'b0000, 7'h00, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1})
            $display("FAIL reset_state: got b%b d%b e%b s%b a%h rw%b c%0d f%b l%0d re%b rdy%b required zeros re=1 rdy=1",
                     busy, done, err, m_start, m_addr, m_rw, m_data_cnt, tx_full, tx_level,
                     rx_empty, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write();
        do_reset();
        host_push(8'hA5);
        host_push(8'h3C);
        host_push(8'h7E);
        n_total++;
        if (tx_level !== 4'd3 || m_tx_data !== 8'hA5)
            $display("FAIL write_prefill level/head: got %0d/%h required 3/a5", tx_level, m_tx_data);
        else n_pass++;
        do_xfer(7'h50, 1'b0, 4'd3, 3, "write");
        n_total++;
        if (tx_level !== 4'd0) $display("FAIL write_drained: got %0d required 0", tx_level);
        else n_pass++;
    endtask

    task automatic test_read();
        do_reset();
        rd_pat.delete();
        rd_pat.push_back(8'h11);
        rd_pat.push_back(8'h22);
        do_xfer(7'h51, 1'b1, 4'd2, 2, "read");
        n_total++;
        if (rx_empty !== 1'b0 || rx_rdata !== 8'h11)
            $display("FAIL read_head0: got %b/%h required 0/11", rx_empty, rx_rdata);
        else n_pass++;
        rx_rd_en = 1'b1;
        step();
        rx_rd_en = 1'b0;
        n_total++;
        if (rx_rdata !== 8'h22) $display("FAIL read_head1: got %h required 22", rx_rdata);
        else n_pass++;
        rx_rd_en = 1'b1;
        step();
        rx_rd_en = 1'b0;
        n_total++;
        if (rx_empty !== 1'b1) $display("FAIL read_empty: got %b required 1", rx_empty);
        else n_pass++;
    endtask

    task automatic test_reject();
        do_reset();
        do_xfer(7'h12, 1'b0, 4'd0, 0, "rej_cnt0");
        host_push(8'h01);
        host_push(8'h02);
        do_xfer(7'h13, 1'b0, 4'd4, 0, "rej_tx_short");
        n_total++;
        if (tx_level !== 4'd2) $display("FAIL rej_tx_kept: got %0d required 2", tx_level);
        else n_pass++;
        for (int i = 0; i < DEPTH - 1; i++) begin
            i_rxff_wr = 1'b1;
            m_rx_data = 8'(i + 8'h40);
            step();
        end
        i_rxff_wr = 1'b0;
        do_xfer(7'h14, 1'b1, 4'd3, 0, "rej_rx_space");
        do_xfer(7'h15, 1'b1, 4'd1, 1, "acc_rx_last_slot");
        n_total++;
        if (rx_rdata !== 8'h40) $display("FAIL rx_head_kept: got %h required 40", rx_rdata);
        else n_pass++;
    endtask

    task automatic test_short();
        do_reset();
        host_push(8'h01);
        host_push(8'h02);
        host_push(8'h03);
        do_xfer(7'h20, 1'b0, 4'd3, 1, "short");
        n_total++;
        if (tx_level !== 4'd2 || m_tx_data !== 8'h02)
            $display("FAIL short_left level/head: got %0d/%h required 2/02", tx_level, m_tx_data);
        else n_pass++;
    endtask

    task automatic test_fifo_bounds();
        do_reset();
        for (int i = 0; i < DEPTH; i++) host_push(8'(i * 17));
        n_total++;
        if (tx_full !== 1'b1 || tx_level !== 4'(DEPTH))
            $display("FAIL fill full/level: got %b/%0d required 1/%0d", tx_full, tx_level, DEPTH);
        else n_pass++;
        host_push(8'hEE);
        n_total++;
        if (tx_level !== 4'(DEPTH) || m_tx_data !== 8'h00)
            $display("FAIL overflow level/head: got %0d/%h required %0d/00", tx_level, m_tx_data, DEPTH);
        else n_pass++;
        i_txff_rd = 1'b1;
        for (int i = 0; i < DEPTH - 4; i++) step();
        i_txff_rd = 1'b0;
        tx_wr_en  = 1'b1;
        i_txff_rd = 1'b1;
        tx_wdata  = 8'hC3;
        step();
        tx_wr_en  = 1'b0;
        i_txff_rd = 1'b0;
        n_total++;
        if (tx_level !== 4'd4 || m_tx_data !== txq[0])
            $display("FAIL push_pop level/head: got %0d/%h required 4/%h", tx_level, m_tx_data, txq[0]);
        else n_pass++;
        // Stream 2*DEPTH bytes through with overlapping push and pop to wrap the pointers.
        do_reset();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            tx_wr_en = 1'b1;
            tx_wdata = 8'($urandom);
            if (i >= 2) begin
                n_total++;
                if (m_tx_data !== txq[0])
                    $display("FAIL wrap_order: got %h required %h", m_tx_data, txq[0]);
                else n_pass++;
                i_txff_rd = 1'b1;
            end
            step();
        end
        tx_wr_en = 1'b0;
        while (txq.size() > 0) begin
            n_total++;
            if (m_tx_data !== txq[0]) $display("FAIL wrap_drain: got %h required %h", m_tx_data, txq[0]);
            else n_pass++;
            i_txff_rd = 1'b1;
            step();
        end
        step();
        i_txff_rd = 1'b0;
        host_push(8'h5A);
        n_total++;
        if (tx_level !== 4'd1 || m_tx_data !== 8'h5A)
            $display("FAIL empty_pop level/head: got %0d/%h required 1/5a", tx_level, m_tx_data);
        else n_pass++;
    endtask

    task automatic test_random();
        int np, cnt, ns;
        logic rw;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) host_push(8'($urandom));
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) begin
                n_total++;
                if (rx_empty !== (rxq.size() == 0))
                    $display("FAIL rand rx_empty: got %b required %b", rx_empty, rxq.size() == 0);
                else n_pass++;
                if (rxq.size() > 0) begin
                    n_total++;
                    if (rx_rdata !== rxq[0])
                        $display("FAIL rand rx_rdata: got %h required %h", rx_rdata, rxq[0]);
                    else n_pass++;
                end
                rx_rd_en = 1'b1;
                step();
                rx_rd_en = 1'b0;
            end
            rw  = 1'($urandom_range(0, 1));
            cnt = $urandom_range(0, 5);
            ns  = ($urandom_range(0, 9) < 7) ? cnt : $urandom_range(0, cnt);
            if (!rw && ns > txq.size()) ns = txq.size();
            do_xfer(7'($urandom), rw, 4'(cnt), ns, "rand");
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        i_rxff_wr = 1'b1;
        m_rx_data = 8'h99;
        step();
        i_rxff_wr = 1'b0;
        host_push(8'hB1);
        host_push(8'hB2);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h33;
        cmd_rw    = 1'b0;
        cmd_cnt   = 4'd2;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        i_txff_rd = 1'b1;
        step();
        i_txff_rd = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL midrun busy: got %b required 1", busy);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if ({busy, done, tx_level, rx_empty, cmd_ready} !== {1'b0, 1'b0, 4'd0, 1'b1, 1'b1})
            $display("FAIL midrun_reset busy/done/lvl/re/rdy: got %b%b/%0d/%b%b required 00/0/11",
                     busy, done, tx_level, rx_empty, cmd_ready);
        else n_pass++;
        do_xfer(7'h34, 1'b1, 4'd1, 1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reject();
        test_short();
        test_fifo_bounds();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
